residual_scale_add: RTL and testbench



---
 rtl/residual_scale_add.sv | 96 +++++++++
 tb/tb_residual_scale_add.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/residual_scale_add.sv
// residual_scale_add: shortcut FIFO + lambda-scaled branch add with saturation and frame_done.
// Optional RESIDUAL_RELU_EN clamps negative sums to zero.
module residual_scale_add #(
  parameter int IMG_SIZE   = 35,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int SCALE      = 11141
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in_1,
  input  logic [DATA_WIDTH-1:0]         pxl_in_1,
  input  logic                          valid_in_2,
  input  logic [DATA_WIDTH-1:0]         pxl_in_2,
  output logic [DATA_WIDTH-1:0]         pxl_out,
  output logic                          valid_out,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overflow,
  output logic                          err_underflow
);
  localparam int W    = DATA_WIDTH;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NPIX = IMG_SIZE * IMG_SIZE;
  localparam int CW   = $clog2(NPIX + 1);
  localparam logic signed [2*W-1:0] SC   = (2*W)'(SCALE);
  localparam logic signed [W-1:0]   MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   MINV = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic empty, full, pop, bypass, push, pair;
  logic [W-1:0] shortcut;
  logic signed [2*W-1:0] prod, shifted;
  logic signed [W-1:0] scaled, s1_short, s1_scaled, sat_sum, res;
  logic signed [W:0] sum;
  logic s1_valid;
  logic [CW-1:0] cnt;
  always_comb begin
    level    = wr_ptr - rd_ptr;
    empty    = level == '0;
    full     = level == (AW+1)'(FIFO_DEPTH);
    pop      = valid_in_2 && !empty;
    bypass   = valid_in_1 && valid_in_2 && empty;
    push     = valid_in_1 && !bypass && (!full || pop);
    pair     = pop || bypass;
    shortcut = pop ? mem[rd_ptr[AW-1:0]] : pxl_in_1;
    prod     = $signed({{W{pxl_in_2[W-1]}}, pxl_in_2}) * SC;
    shifted  = prod >>> FRAC_BITS;
    scaled   = (&shifted[2*W-1:W-1] || ~|shifted[2*W-1:W-1]) ? shifted[W-1:0] :
               shifted[2*W-1] ? MINV : MAXV;
    sum      = {s1_short[W-1], s1_short} + {s1_scaled[W-1], s1_scaled};
    sat_sum  = (sum[W] == sum[W-1]) ? sum[W-1:0] : sum[W] ? MINV : MAXV;
`ifdef RESIDUAL_RELU_EN
    res      = sat_sum[W-1] ? '0 : sat_sum;
`else
    res      = sat_sum;
`endif
  end
  assign fifo_level = level;
  // Storage is left unreset: contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pxl_in_1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      s1_valid      <= 1'b0;
      s1_short      <= '0;
      s1_scaled     <= '0;
      valid_out     <= 1'b0;
      frame_done    <= 1'b0;
      pxl_out       <= '0;
      cnt           <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (valid_in_1 && full && !pop) err_overflow <= 1'b1;
      if (valid_in_2 && empty && !valid_in_1) err_underflow <= 1'b1;
      s1_valid <= pair;
      if (pair) begin
        s1_short  <= shortcut;
        s1_scaled <= scaled;
      end
      valid_out  <= s1_valid;
      frame_done <= s1_valid && cnt == CW'(NPIX - 1);
      if (s1_valid) begin
        pxl_out <= res;
        cnt     <= (cnt == CW'(NPIX - 1)) ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_residual_scale_add.sv
// tb_residual_scale_add: directed + random stimulus against a queue-based arithmetic reference.
module tb_residual_scale_add;
  localparam int IMG   = 3;
  localparam int DEPTH = 16;
  localparam int SCL   = 98304;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;
  typedef struct {
    int          due;
    logic [31:0] v;
    logic        fd;
  } exp_t;
  logic clk = 0, reset = 1;
  logic valid_in_1 = 0, valid_in_2 = 0;
  logic [31:0] pxl_in_1 = 0, pxl_in_2 = 0;
  logic [31:0] pxl_out;
  logic valid_out, frame_done, err_overflow, err_underflow;
  logic [4:0] fifo_level;
  logic [31:0] q[$];
  exp_t eq[$];
  int cyc = 0, out_cnt = 0, n_asrt = 0, n_fail = 0, peak = 0;
  logic m_ovf = 0, m_unf = 0;
  residual_scale_add #(.IMG_SIZE(IMG), .DATA_WIDTH(32), .FRAC_BITS(16),
                       .FIFO_DEPTH(DEPTH), .SCALE(SCL)) dut (
    .clk(clk), .reset(reset), .valid_in_1(valid_in_1), .pxl_in_1(pxl_in_1),
    .valid_in_2(valid_in_2), .pxl_in_2(pxl_in_2), .pxl_out(pxl_out),
    .valid_out(valid_out), .frame_done(frame_done), .fifo_level(fifo_level),
    .err_overflow(err_overflow), .err_underflow(err_underflow));
  always #5 clk = ~clk;
  function automatic longint clamp(longint x);
    return x > LMAX ? LMAX : x < LMIN ? LMIN : x;
  endfunction
  function automatic logic [31:0] ref_out(logic [31:0] s, logic [31:0] b);
    longint sc, sum;
    sc  = clamp((longint'($signed(b)) * longint'(SCL)) >>> 16);
    sum = clamp(longint'($signed(s)) + sc);
`ifdef RESIDUAL_RELU_EN
    if (sum < 0) sum = 0;
`endif
    return 32'(sum);
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, o, e, cyc);
    end
  endtask
  task automatic check_outputs();
    logic ev;
    ev = eq.size() > 0 && eq[0].due == cyc;
    chk("valid_out", 32'(valid_out), 32'(ev));
    if (ev) begin
      chk("pxl_out", pxl_out, eq[0].v);
      chk("frame_done", 32'(frame_done), 32'(eq[0].fd));
      void'(eq.pop_front());
    end else chk("frame_done_idle", 32'(frame_done), 0);
    chk("fifo_level", 32'(fifo_level), q.size());
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_unf));
  endtask
  task automatic step(input logic v1, input logic [31:0] p1, input logic v2, input logic [31:0] p2);
    logic empty, full, pop, byp, push;
    logic [31:0] s;
    valid_in_1 = v1; pxl_in_1 = p1; valid_in_2 = v2; pxl_in_2 = p2;
    empty = q.size() == 0;
    full  = q.size() == DEPTH;
    pop   = v2 && !empty;
    byp   = v1 && v2 && empty;
    push  = v1 && !byp && (!full || pop);
    if (v1 && full && !pop) m_ovf = 1;
    if (v2 && empty && !v1) m_unf = 1;
    if (pop || byp) begin
      s = pop ? q.pop_front() : p1;
      eq.push_back('{due: cyc + 2, v: ref_out(s, p2), fd: (out_cnt % (IMG*IMG)) == IMG*IMG - 1});
      out_cnt++;
    end
    if (push) q.push_back(p1);
    if (q.size() > peak) peak = q.size();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom, 0, $urandom);
  endtask
  task automatic reset_checks();
    chk("rst_pxl_out", pxl_out, 0);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    chk("rst_err_overflow", 32'(err_overflow), 0);
    chk("rst_err_underflow", 32'(err_underflow), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    reset = 0;
    idle(2);
    // bypass pair on an empty FIFO
    step(1, 32'h0001_0000, 1, 32'h0002_0000);
    idle(3);
    // shortcut leads branch by 10
    peak = 0;
    for (int k = 1; k <= 10; k++) step(1, 32'h0001_0000 * k, 0, 0);
    chk("lead_peak", peak, 10);
    for (int k = 1; k <= 10; k++) step(0, 0, 1, 0);
    idle(3);
    // saturation corners in both stages
    step(1, 32'h7FFF_0000, 1, 32'h7FFF_0000);
    step(1, 32'h8000_0000, 1, 32'hFFFF_0000);
    step(1, 32'h8000_0000, 1, 32'h8000_0000);
    step(1, 32'h0000_0000, 1, 32'h6000_0000);
    step(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    idle(3);
    // frame boundaries across 19 back-to-back bypass pairs
    for (int i = 0; i < 19; i++) step(1, $urandom, 1, $urandom);
    idle(3);
    // branch pixel alone on an empty FIFO
    step(0, 0, 1, 32'h1234_5678);
    idle(3);
    // overflow, then full push+pop, then drain
    for (int i = 0; i <= DEPTH; i++) step(1, 32'h100 + i, 0, 0);
    step(1, 32'hABCD_0000, 1, 32'h0001_0000);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, $urandom);
    idle(3);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50, $urandom);
    while (q.size() > 0) step(0, 0, 1, $urandom);
    idle(3);
    // reset mid-stream: 5 queued entries and pairs in flight
    for (int i = 0; i < 7; i++) step(1, $urandom, 0, 0);
    step(0, 0, 1, $urandom);
    step(0, 0, 1, $urandom);
    chk("pre_reset_level", 32'(fifo_level), 5);
    valid_in_1 = 0; valid_in_2 = 0;
    #2 reset = 1;
    #1 reset_checks();
    q.delete(); eq.delete(); out_cnt = 0; m_ovf = 0; m_unf = 0;
    @(posedge clk);
    #1 reset = 0;
    idle(5);
    // fresh frame count after reset
    for (int i = 0; i < 10; i++) step(1, $urandom, 1, $urandom);
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
